// File: rtl/core_pkg.sv
// core_pkg: shared constants for the RV32I multi-cycle datapath.
// Holds the sequencer state encoding, the default memory-handshake
// timeout, the decoder's select-field constants and the decode-flag record.
package core_pkg;

    // Sequencer state encoding; also the value seen on the debug state port.
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_FETCH     = 3'd1;
    localparam logic [2:0] ST_DECODE    = 3'd2;
    localparam logic [2:0] ST_EXECUTE   = 3'd3;
    localparam logic [2:0] ST_MEMORY    = 3'd4;
    localparam logic [2:0] ST_WRITEBACK = 3'd5;
    localparam logic [2:0] ST_HALT      = 3'd6;

    // Cycles a memory handshake may stall before it is treated as a bus error.
    localparam int unsigned WAIT_LIMIT_DEFAULT = 255;

    // Decoder pc_select field.
    localparam logic [1:0] PC_SEL_PLUS4  = 2'd0;
    localparam logic [1:0] PC_SEL_BRANCH = 2'd1;
    localparam logic [1:0] PC_SEL_JAL    = 2'd2;
    localparam logic [1:0] PC_SEL_JALR   = 2'd3;

    // Decoder writeback-source select field.
    localparam logic [1:0] WB_SEL_ALU  = 2'd0;
    localparam logic [1:0] WB_SEL_MEM  = 2'd1;
    localparam logic [1:0] WB_SEL_PC4  = 2'd2;
    localparam logic [1:0] WB_SEL_IMM  = 2'd3;

    // Decoder flags captured at the end of DECODE.
    typedef struct packed {
        logic is_load;
        logic is_store;
        logic write_enable;
    } dec_flags_t;

    // True for states in which an instruction is in flight.
    function automatic logic state_is_active(input logic [2:0] s);
        return (s != ST_IDLE) && (s != ST_HALT);
    endfunction

endpackage

// File: rtl/perf_counter.sv
// perf_counter: WIDTH-bit wrapping event counter with increment enable and
// synchronous clear. Only instantiated by core_sequencer when
// CORE_SEQUENCER_PERF_COUNTERS_EN is defined.
module perf_counter
    import core_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_clear,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    // Count enabled events, wrapping at 2^WIDTH; clear has priority.
    always_ff @(posedge i_clk) begin
        if (i_clear) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK
// sequencer for the RV32I datapath. Runs the instruction and data memory
// handshakes, gates the decoder's write strobes and halts on an illegal
// opcode or a handshake timeout.
// Optional feature: CORE_SEQUENCER_PERF_COUNTERS_EN builds the cycle and
// retired-instruction counters; without it both counter ports read 0.
//
// state     | meaning
// IDLE      | waiting for run
// FETCH     | instruction request outstanding until imem_valid
// DECODE    | decoder flags captured
// EXECUTE   | ALU cycle; picks MEMORY or WRITEBACK
// MEMORY    | data request outstanding until dmem_ready
// WRITEBACK | register/PC write strobes fire
// HALT      | illegal opcode or bus error; left only by reset
module core_sequencer
    import core_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT    = WAIT_LIMIT_DEFAULT,
    parameter int unsigned COUNTER_WIDTH = 32
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_run,
    output logic                     o_imem_req,
    input  logic                     i_imem_valid,
    output logic                     o_instruction_load,
    input  logic                     i_decode_is_load,
    input  logic                     i_decode_is_store,
    input  logic                     i_decode_write_enable,
    input  logic                     i_decode_illegal,
    output logic                     o_dmem_req,
    output logic                     o_dmem_write,
    input  logic                     i_dmem_ready,
    output logic                     o_register_write_enable,
    output logic                     o_pc_write_enable,
    output logic                     o_halted,
    output logic                     o_bus_error,
    output logic [2:0]               o_state,
    output logic [COUNTER_WIDTH-1:0] o_cycle_count,
    output logic [COUNTER_WIDTH-1:0] o_retired_count
);

    localparam int unsigned WAIT_W = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);
    // Count value during the last permitted stall cycle.
    localparam logic [WAIT_W-1:0] WAIT_TC = WAIT_W'(WAIT_LIMIT - 1);

    logic [2:0]        r_state;
    dec_flags_t        r_flags;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_bus_error;

    logic [2:0]        w_next_state;
    logic              w_timeout;
    logic              w_pending;
    logic              w_limit_cycle;

    assign w_limit_cycle = (WAIT_LIMIT != 0) && (r_wait_cnt == WAIT_TC);
    assign w_pending     = ((r_state == ST_FETCH)  && !i_imem_valid) ||
                           ((r_state == ST_MEMORY) && !i_dmem_ready);

    // Next-state selection; a handshake arriving in the limit cycle wins over the timeout.
    always_comb begin
        w_next_state = r_state;
        w_timeout    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_run) w_next_state = ST_FETCH;
            end
            ST_FETCH: begin
                if (i_imem_valid) begin
                    w_next_state = ST_DECODE;
                end else if (w_limit_cycle) begin
                    w_next_state = ST_HALT;
                    w_timeout    = 1'b1;
                end
            end
            ST_DECODE: begin
                w_next_state = i_decode_illegal ? ST_HALT : ST_EXECUTE;
            end
            ST_EXECUTE: begin
                w_next_state = (r_flags.is_load || r_flags.is_store) ? ST_MEMORY : ST_WRITEBACK;
            end
            ST_MEMORY: begin
                if (i_dmem_ready) begin
                    w_next_state = ST_WRITEBACK;
                end else if (w_limit_cycle) begin
                    w_next_state = ST_HALT;
                    w_timeout    = 1'b1;
                end
            end
            ST_WRITEBACK: begin
                w_next_state = i_run ? ST_FETCH : ST_IDLE;
            end
            ST_HALT: begin
                w_next_state = ST_HALT;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // State, captured decode flags, handshake wait counter and sticky bus error.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_flags     <= '0;
            r_wait_cnt  <= '0;
            r_bus_error <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (r_state == ST_DECODE) begin
                r_flags.is_load      <= i_decode_is_load;
                r_flags.is_store     <= i_decode_is_store;
                r_flags.write_enable <= i_decode_write_enable;
            end
            if (w_next_state != r_state) begin
                r_wait_cnt <= '0;
            end else if (w_pending) begin
                r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
            end
            if (w_timeout) begin
                r_bus_error <= 1'b1;
            end
        end
    end

    // instruction_load follows FETCH rather than imem_valid so no output
    // depends combinationally on a handshake input; the register keeps the
    // word presented in the final (valid) FETCH cycle.
    assign o_imem_req              = (r_state == ST_FETCH);
    assign o_instruction_load      = (r_state == ST_FETCH);
    assign o_dmem_req              = (r_state == ST_MEMORY);
    assign o_dmem_write            = (r_state == ST_MEMORY) && r_flags.is_store;
    assign o_register_write_enable = (r_state == ST_WRITEBACK) && r_flags.write_enable;
    assign o_pc_write_enable       = (r_state == ST_WRITEBACK);
    assign o_halted                = (r_state == ST_HALT);
    assign o_bus_error             = r_bus_error;
    assign o_state                 = r_state;

`ifdef CORE_SEQUENCER_PERF_COUNTERS_EN
    logic w_active;
    logic w_retire;

    assign w_active = state_is_active(r_state);
    assign w_retire = (r_state == ST_WRITEBACK);

    perf_counter #(.WIDTH(COUNTER_WIDTH)) u_cycle_counter (
        .i_clk   (i_clk),
        .i_clear (i_reset),
        .i_inc   (w_active),
        .o_count (o_cycle_count)
    );

    perf_counter #(.WIDTH(COUNTER_WIDTH)) u_retired_counter (
        .i_clk   (i_clk),
        .i_clear (i_reset),
        .i_inc   (w_retire),
        .o_count (o_retired_count)
    );
`else
    assign o_cycle_count   = '0;
    assign o_retired_count = '0;
`endif

endmodule

// File: tb/tb_core_sequencer.sv
// tb_core_sequencer: self-checking bench for core_sequencer (WAIT_LIMIT=4).
// Directed vector table, hand-written timeout/reset sequences, then random
// instruction streams checked against a per-instruction timeline model.
module tb_core_sequencer;

    localparam int LIMIT = 4;
    localparam int CW    = 32;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;

`ifdef CORE_SEQUENCER_PERF_COUNTERS_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset, run, imem_valid, dmem_ready;
    logic          d_ld, d_st, d_we, d_ill;
    logic          imem_req, instruction_load, dmem_req, dmem_write;
    logic          register_write_enable, pc_write_enable, halted, bus_error;
    logic [2:0]    state;
    logic [CW-1:0] cycle_count, retired_count;

    core_sequencer #(.WAIT_LIMIT(LIMIT), .COUNTER_WIDTH(CW)) dut (
        .i_clk                   (clk),
        .i_reset                 (reset),
        .i_run                   (run),
        .o_imem_req              (imem_req),
        .i_imem_valid            (imem_valid),
        .o_instruction_load      (instruction_load),
        .i_decode_is_load        (d_ld),
        .i_decode_is_store       (d_st),
        .i_decode_write_enable   (d_we),
        .i_decode_illegal        (d_ill),
        .o_dmem_req              (dmem_req),
        .o_dmem_write            (dmem_write),
        .i_dmem_ready            (dmem_ready),
        .o_register_write_enable (register_write_enable),
        .o_pc_write_enable       (pc_write_enable),
        .o_halted                (halted),
        .o_bus_error             (bus_error),
        .o_state                 (state),
        .o_cycle_count           (cycle_count),
        .o_retired_count         (retired_count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model: counters of cycles seen so far and the flags of the instruction in flight.
    int unsigned m_cyc, m_ret;
    bit          m_buserr, m_store, m_we;

    // ins = {run, imem_valid, dmem_ready, is_load, is_store, write_enable, illegal}
    // exp = {imem_req, instruction_load, dmem_req, dmem_write, reg_we, pc_we, halted}
    typedef struct packed {
        logic [6:0] ins;
        logic [2:0] s;
        logic [6:0] exp;
    } vec_t;

    vec_t vecs[24];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic logic [6:0] strobes_for(input logic [2:0] s);
        return {s == S_FETCH, s == S_FETCH, s == S_MEM, (s == S_MEM) && m_store,
                (s == S_WB) && m_we, s == S_WB, s == S_HALT};
    endfunction

    task automatic drive(input logic [6:0] ins);
        reset = 1'b0;
        {run, imem_valid, dmem_ready, d_ld, d_st, d_we, d_ill} = ins;
    endtask

    task automatic check_outputs(input logic [2:0] s, input logic [6:0] exp);
        chk("state", 32'(state), 32'(s));
        chk("strobes{ireq,iload,dreq,dwr,rwe,pwe,halt}",
            32'({imem_req, instruction_load, dmem_req, dmem_write,
                 register_write_enable, pc_write_enable, halted}), 32'(exp));
        chk("bus_error", 32'(bus_error), 32'(m_buserr));
        chk("cycle_count", cycle_count, PERF ? m_cyc : 32'd0);
        chk("retired_count", retired_count, PERF ? m_ret : 32'd0);
        if (s != S_IDLE && s != S_HALT) m_cyc++;
        if (s == S_WB) m_ret++;
    endtask

    // One clock: drive this cycle's inputs, then compare against the phase the model expects.
    task automatic cycle(input logic [2:0] s, input logic r, input logic iv, input logic dr,
                         input logic ld, input logic st, input logic we, input logic ill);
        @(negedge clk);
        drive({r, iv, dr, ld, st, we, ill});
        #1;
        check_outputs(s, strobes_for(s));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        {run, imem_valid, dmem_ready, d_ld, d_st, d_we, d_ill} = '0;
        m_cyc = 0; m_ret = 0; m_buserr = 1'b0; m_store = 1'b0; m_we = 1'b0;
    endtask

    // One instruction from its first FETCH cycle through WRITEBACK (or into HALT).
    // fs/ms: stall cycles before valid/ready; kind 0=ALU 1=load 2=store.
    task automatic run_instr(input int fs, input int kind, input int ms, input logic we,
                             input logic ill, input logic run_after, output bit hit_halt);
        bit got;
        hit_halt = 1'b0;
        got = 1'b0;
        for (int k = 0; k < LIMIT; k++) begin
            got = (k == fs);
            cycle(S_FETCH, rb(), got, rb(), rb(), rb(), rb(), rb());
            if (got) break;
        end
        if (!got) begin
            m_buserr = 1'b1;
            hit_halt = 1'b1;
            return;
        end
        cycle(S_DECODE, rb(), rb(), rb(), kind == 1, kind == 2, we, ill);
        m_store = (kind == 2);
        m_we    = we;
        if (ill) begin
            hit_halt = 1'b1;
            return;
        end
        cycle(S_EXEC, rb(), rb(), rb(), rb(), rb(), rb(), rb());
        if (kind != 0) begin
            got = 1'b0;
            for (int k = 0; k < LIMIT; k++) begin
                got = (k == ms);
                cycle(S_MEM, rb(), rb(), got, rb(), rb(), rb(), rb());
                if (got) break;
            end
            if (!got) begin
                m_buserr = 1'b1;
                hit_halt = 1'b1;
                return;
            end
        end
        cycle(S_WB, run_after, rb(), rb(), rb(), rb(), rb(), rb());
    endtask

    function automatic int pick_stall();
        return ($urandom_range(0, 7) == 0) ? int'($urandom_range(3, 5)) : int'($urandom_range(0, 2));
    endfunction

    initial begin
        bit h;
        int fs, ms, kind;
        logic we, ill, ra;

        vecs = '{
            // addi, imem_valid immediately; junk inputs in FETCH/EXECUTE are ignored
            '{7'b1000000, S_IDLE,   7'b0000000},
            '{7'b1110001, S_FETCH,  7'b1100000},
            '{7'b1000010, S_DECODE, 7'b0000000},
            '{7'b0111101, S_EXEC,   7'b0000000},
            '{7'b1000000, S_WB,     7'b0000110},
            // load, dmem_ready after 3 stall cycles; run low in FETCH is ignored
            '{7'b0100000, S_FETCH,  7'b1100000},
            '{7'b1001010, S_DECODE, 7'b0000000},
            '{7'b1000000, S_EXEC,   7'b0000000},
            '{7'b1000000, S_MEM,    7'b0010000},
            '{7'b1000000, S_MEM,    7'b0010000},
            '{7'b1000000, S_MEM,    7'b0010000},
            '{7'b1010000, S_MEM,    7'b0010000},
            '{7'b1000000, S_WB,     7'b0000110},
            // store, one MEMORY stall, then run low at WRITEBACK
            '{7'b1100000, S_FETCH,  7'b1100000},
            '{7'b1000100, S_DECODE, 7'b0000000},
            '{7'b1000000, S_EXEC,   7'b0000000},
            '{7'b1100000, S_MEM,    7'b0011000},
            '{7'b1010000, S_MEM,    7'b0011000},
            '{7'b0000000, S_WB,     7'b0000010},
            '{7'b1000000, S_IDLE,   7'b0000000},
            // illegal opcode halts with no write strobes
            '{7'b1100000, S_FETCH,  7'b1100000},
            '{7'b1000011, S_DECODE, 7'b0000000},
            '{7'b1110000, S_HALT,   7'b0000001},
            '{7'b1111110, S_HALT,   7'b0000001}
        };

        reset = 1'b1;
        {run, imem_valid, dmem_ready, d_ld, d_st, d_we, d_ill} = '0;
        m_cyc = 0; m_ret = 0; m_buserr = 1'b0; m_store = 1'b0; m_we = 1'b0;
        repeat (2) @(negedge clk);

        // reset state
        cycle(S_IDLE, 0, 1, 1, 1, 1, 1, 1);

        for (int i = 0; i < $size(vecs); i++) begin
            @(negedge clk);
            drive(vecs[i].ins);
            #1;
            check_outputs(vecs[i].s, vecs[i].exp);
        end

        // imem_valid never arrives: four FETCH cycles, then HALT with bus_error
        do_reset();
        cycle(S_IDLE, 1, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < LIMIT; k++) cycle(S_FETCH, rb(), 0, rb(), rb(), rb(), rb(), rb());
        m_buserr = 1'b1;
        repeat (3) cycle(S_HALT, 1, 1, 1, rb(), rb(), rb(), rb());
        do_reset();
        cycle(S_IDLE, 0, 0, 0, 0, 0, 0, 0);

        // handshakes arriving in the limit cycle win
        cycle(S_IDLE, 1, 0, 0, 0, 0, 0, 0);
        run_instr(LIMIT - 1, 1, LIMIT - 1, 1'b1, 1'b0, 1'b0, h);
        cycle(S_IDLE, 1, 0, 0, 0, 0, 0, 0);

        // reset during MEMORY drops the request at the next edge
        cycle(S_FETCH, 1, 1, 0, 0, 0, 0, 0);
        cycle(S_DECODE, 1, 0, 0, 1, 0, 1, 0);
        m_store = 1'b0; m_we = 1'b1;
        cycle(S_EXEC, 1, 0, 0, 0, 0, 0, 0);
        cycle(S_MEM, 1, 0, 0, 0, 0, 0, 0);
        do_reset();
        cycle(S_IDLE, 0, 0, 1, 0, 0, 0, 0);

        // random instruction streams
        cycle(S_IDLE, 1, rb(), rb(), rb(), rb(), rb(), rb());
        for (int n = 0; n < 150; n++) begin
            fs   = pick_stall();
            ms   = pick_stall();
            kind = int'($urandom_range(0, 2));
            we   = rb();
            ill  = ($urandom_range(0, 9) == 0);
            ra   = ($urandom_range(0, 3) != 0);
            run_instr(fs, kind, ms, we, ill, ra, h);
            if (h) begin
                repeat ($urandom_range(1, 3)) cycle(S_HALT, rb(), rb(), rb(), rb(), rb(), rb(), rb());
                do_reset();
                cycle(S_IDLE, 1, rb(), rb(), rb(), rb(), rb(), rb());
            end else if (!ra) begin
                repeat ($urandom_range(0, 2)) cycle(S_IDLE, 0, rb(), rb(), rb(), rb(), rb(), rb());
                cycle(S_IDLE, 1, rb(), rb(), rb(), rb(), rb(), rb());
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
